// File: rtl/pick_voq_rr_if.sv
// pick_voq_rr_if: bundles the selection/commit signals of one ingress VOQ picker.
//
// Optional feature macro: PICK_VOQ_STATS_EN (adds the CNT_W parameter and grant_cnt).
//
// Signals:
//   start_voq_num    caller -> picker  round-robin start index
//   voq_empty        caller -> picker  bit i = 1: VOQ i empty
//   voq_picked       caller -> picker  bit i = 1: egress i already claimed
//   pick_commit      caller -> picker  accept current pick this cycle
//   no_available_voq picker -> caller  no eligible VOQ (combinational)
//   voq_to_pick      picker -> caller  selected VOQ (combinational)
//   last_pick        picker -> caller  registered last committed pick
//   last_pick_valid  picker -> caller  registered, set after first commit
//   grant_cnt        picker -> caller  per-VOQ grant counters (stats build only)
interface pick_voq_rr_if #(
    parameter int unsigned N_VOQ = 4
`ifdef PICK_VOQ_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
);
    localparam int unsigned IDX_W = $clog2(N_VOQ);

    logic [IDX_W-1:0] start_voq_num;
    logic [N_VOQ-1:0] voq_empty;
    logic [N_VOQ-1:0] voq_picked;
    logic             pick_commit;
    logic             no_available_voq;
    logic [IDX_W-1:0] voq_to_pick;
    logic [IDX_W-1:0] last_pick;
    logic             last_pick_valid;
`ifdef PICK_VOQ_STATS_EN
    logic [N_VOQ*CNT_W-1:0] grant_cnt;

    modport master (
        output start_voq_num, voq_empty, voq_picked, pick_commit,
        input  no_available_voq, voq_to_pick, last_pick, last_pick_valid, grant_cnt
    );
    modport slave (
        input  start_voq_num, voq_empty, voq_picked, pick_commit,
        output no_available_voq, voq_to_pick, last_pick, last_pick_valid, grant_cnt
    );
`else
    modport master (
        output start_voq_num, voq_empty, voq_picked, pick_commit,
        input  no_available_voq, voq_to_pick, last_pick, last_pick_valid
    );
    modport slave (
        input  start_voq_num, voq_empty, voq_picked, pick_commit,
        output no_available_voq, voq_to_pick, last_pick, last_pick_valid
    );
`endif
endinterface

// File: rtl/pick_voq_rr.sv
// pick_voq_rr: per-ingress round-robin VOQ selector for the crossbar scheduler.
// Returns, combinationally, the first non-empty and unclaimed VOQ searching upward
// (with wrap) from start_voq_num, and records the last committed pick.
//
// Optional feature macro: PICK_VOQ_STATS_EN adds saturating per-VOQ grant counters
// (CNT_W bits each) exported on bus.grant_cnt.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset (clears registered state only)
//   bus    pick_voq_rr_if.slave, see the interface for signal descriptions
module pick_voq_rr #(
    parameter int unsigned N_VOQ = 4
`ifdef PICK_VOQ_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input logic         clk,
    input logic         reset,
    pick_voq_rr_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(N_VOQ);

    logic [N_VOQ-1:0] eligible;
    logic [N_VOQ-1:0] rot;
    logic [IDX_W-1:0] offset;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic             commit_ok;

    logic [IDX_W-1:0] last_pick_q, last_pick_d;
    logic             last_pick_valid_q, last_pick_valid_d;

    // Selection: rot[k] is eligibility of candidate start+k; the lowest set bit of
    // rot is the round-robin winner. Index arithmetic wraps because N_VOQ is 2^IDX_W.
    always_comb begin
        eligible = ~bus.voq_empty & ~bus.voq_picked;
        rot      = '0;
        for (int k = 0; k < N_VOQ; k++) begin
            rot[k] = eligible[bus.start_voq_num + IDX_W'(k)];
        end
        found  = 1'b0;
        offset = '0;
        for (int k = N_VOQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found  = 1'b1;
                offset = IDX_W'(k);
            end
        end
        // offset stays 0 when nothing is eligible, so pick falls back to start.
        pick = bus.start_voq_num + offset;
    end

    assign bus.no_available_voq = ~found;
    assign bus.voq_to_pick      = pick;
    assign commit_ok            = bus.pick_commit & found;

    always_comb begin
        last_pick_d       = last_pick_q;
        last_pick_valid_d = last_pick_valid_q;
        if (commit_ok) begin
            last_pick_d       = pick;
            last_pick_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_pick_q       <= '0;
            last_pick_valid_q <= 1'b0;
        end else begin
            last_pick_q       <= last_pick_d;
            last_pick_valid_q <= last_pick_valid_d;
        end
    end

    assign bus.last_pick       = last_pick_q;
    assign bus.last_pick_valid = last_pick_valid_q;

`ifdef PICK_VOQ_STATS_EN
    // Packed so that VOQ i lands at grant_cnt[i*CNT_W +: CNT_W].
    logic [N_VOQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // Saturate at all-ones instead of wrapping.
        if (commit_ok && (cnt_q[pick] != '1)) begin
            cnt_d[pick] = cnt_q[pick] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pick_voq_rr.sv
// Self-checking bench for pick_voq_rr: directed cases followed by random traffic,
// compared against a search-order reference model. Stats checks are compiled in
// only when PICK_VOQ_STATS_EN is defined.
module tb_pick_voq_rr;
    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int CW    = 4;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    // Reference state
    int   m_last;
    bit   m_valid;
    int   m_cnt [N];

`ifdef PICK_VOQ_STATS_EN
    pick_voq_rr_if #(.N_VOQ(N), .CNT_W(CW)) bus ();
    pick_voq_rr #(.N_VOQ(N), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    pick_voq_rr_if #(.N_VOQ(N)) bus ();
    pick_voq_rr #(.N_VOQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Walk candidates in search order and return the first eligible one.
    function automatic void ref_pick(input int s, input logic [N-1:0] e, input logic [N-1:0] p,
                                     output int pick, output bit none);
        none = 1'b1;
        pick = s;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (s + k) % N;
            if (none && !e[idx] && !p[idx]) begin
                none = 1'b0;
                pick = idx;
            end
        end
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_comb(input string tag);
        int  ep;
        bit  en;
        ref_pick(int'(bus.start_voq_num), bus.voq_empty, bus.voq_picked, ep, en);
        chk({tag, ".none"}, int'(bus.no_available_voq), int'(en));
        chk({tag, ".pick"}, int'(bus.voq_to_pick), ep);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".last"}, int'(bus.last_pick), m_last);
        chk({tag, ".valid"}, int'(bus.last_pick_valid), int'(m_valid));
`ifdef PICK_VOQ_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.cnt%0d", tag, i), int'(bus.grant_cnt[i*CW +: CW]), m_cnt[i]);
        end
`endif
    endtask

    task automatic apply(input int s, input logic [N-1:0] e, input logic [N-1:0] p);
        bus.start_voq_num = IDX_W'(s);
        bus.voq_empty     = e;
        bus.voq_picked    = p;
        #1;
    endtask

    // One clock with the given commit/reset; model follows the rules from the inputs
    // present at the edge.
    task automatic cycle(input bit c, input bit r);
        int ep;
        bit en;
        bus.pick_commit = c;
        reset           = r;
        ref_pick(int'(bus.start_voq_num), bus.voq_empty, bus.voq_picked, ep, en);
        @(posedge clk);
        #1;
        if (r) begin
            m_last  = 0;
            m_valid = 1'b0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (c && !en) begin
            m_last  = ep;
            m_valid = 1'b1;
            if (m_cnt[ep] < (1 << CW) - 1) m_cnt[ep]++;
        end
        bus.pick_commit = 1'b0;
        reset           = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_last      = 0;
        m_valid     = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        bus.pick_commit = 1'b0;
        reset           = 1'b1;

        // Combinational path must be valid during reset.
        apply(0, 4'b0000, 4'b0000);
        check_comb("basic_in_reset");
        chk("basic_pick_const", int'(bus.voq_to_pick), 0);
        cycle(1'b0, 1'b1);
        check_state("after_reset");

        apply(3, 4'b0110, 4'b0000);
        check_comb("rot3");
        chk("rot3_const", int'(bus.voq_to_pick), 3);
        apply(3, 4'b1110, 4'b0000);
        check_comb("wrap");
        chk("wrap_const", int'(bus.voq_to_pick), 0);
        apply(1, 4'b0001, 4'b0110);
        check_comb("skip_claimed");
        chk("skip_const", int'(bus.voq_to_pick), 3);
        apply(1, 4'b0001, 4'b1110);
        check_comb("all_claimed");
        chk("all_claimed_none", int'(bus.no_available_voq), 1);
        chk("all_claimed_start", int'(bus.voq_to_pick), 1);
        for (int s = 0; s < N; s++) begin
            apply(s, 4'b1111, 4'($urandom));
            check_comb($sformatf("all_empty_s%0d", s));
        end

        // Commit pick=2, then a no-op commit with nothing eligible.
        apply(2, 4'b0000, 4'b0000);
        cycle(1'b1, 1'b0);
        check_state("commit2");
        chk("commit2_const", int'(bus.last_pick), 2);
        apply(0, 4'b1111, 4'b0000);
        cycle(1'b1, 1'b0);
        check_state("commit_none");
        apply(1, 4'b0000, 4'b0000);
        cycle(1'b1, 1'b1);
        check_state("reset_with_commit");
        chk("reset_with_commit_valid", int'(bus.last_pick_valid), 0);

        // Three commits of VOQ 1, then enough to pass saturation.
        apply(1, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        check_state("three_of_1");
`ifdef PICK_VOQ_STATS_EN
        chk("three_of_1_const", int'(bus.grant_cnt[1*CW +: CW]), 3);
`endif
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0);
        check_state("saturate");
`ifdef PICK_VOQ_STATS_EN
        chk("saturate_const", int'(bus.grant_cnt[1*CW +: CW]), 15);
`endif

        // Random traffic.
        for (int t = 0; t < 300; t++) begin
            apply(int'($urandom_range(0, N - 1)), 4'($urandom), 4'($urandom & $urandom));
            check_comb($sformatf("rnd%0d", t));
            cycle(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
            check_state($sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
